// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  // Smallest ratio that still yields a real high and low phase.
  localparam int unsigned MIN_DIV = 2;

  // Number of whole clk cycles the output spends high for a given ratio.
  function automatic int unsigned half(input int unsigned div);
    return div >> 1;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter plus posedge/negedge phase flops producing a 50 % duty clk_out.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic [CNT_W-1:0] div,
  output logic             wrap,
  output logic             clk_out
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             active;
  logic             pos_q;
  logic             neg_q;
  logic             at_end;

  // A period boundary is either the very first edge after starting or the last count.
  assign at_end  = (cnt == (div - CNT_W'(1)));
  assign wrap    = run & (~active | at_end);
  assign cnt_nxt = wrap ? '0 : (cnt + CNT_W'(1));

  // Counter and high-phase flop; clear parks everything low at a boundary or in idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      pos_q  <= 1'b0;
      active <= 1'b0;
    end else if (clear) begin
      cnt    <= '0;
      pos_q  <= 1'b0;
      active <= 1'b0;
    end else if (run) begin
      active <= 1'b1;
      cnt    <= cnt_nxt;
      pos_q  <= (32'(cnt_nxt) < half(32'(div)));
    end
  end

  // Half-cycle delayed copy of pos_q that stretches odd ratios by half a clk.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  // Odd ratios OR in the negedge phase; switches only when pos_q rises at a boundary.
  assign clk_out = div[0] ? (pos_q | neg_q) : pos_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock divider: enable sequencing, ratio handshake, boundary-aligned ratio switch.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] cur_div,
  output logic             running
);

  state_t           state;
  logic             pend_valid;
  logic [CNT_W-1:0] pend_div;
  logic             wrap;
  logic             clear;
  logic             run;
  logic             accept;
  logic             legal;
  logic             apply;

  // The core is held cleared in idle and at the boundary that ends a stop.
  assign run    = (state != IDLE);
  assign clear  = (state == IDLE) | ((state == STOP) & wrap & ~en);
  assign accept = cfg_valid & cfg_ready;
  assign legal  = (32'(cfg_div) >= MIN_DIV);
  assign apply  = pend_valid & ((state == IDLE) | wrap);

  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .run     (run),
    .div     (cur_div),
    .wrap    (wrap),
    .clk_out (clk_out)
  );

  // Enable FSM, pending-ratio register, handshake and pulse generation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      running    <= 1'b0;
      tick       <= 1'b0;
      cfg_err    <= 1'b0;
      cfg_ready  <= 1'b1;
      cur_div    <= CNT_W'(DEFAULT_DIV);
      pend_valid <= 1'b0;
      pend_div   <= '0;
    end else begin
      tick    <= wrap & ~clear;
      cfg_err <= accept & ~legal;

      case (state)
        IDLE: begin
          if (en) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (!en) begin
            state <= STOP;
          end
        end
        STOP: begin
          if (en) begin
            state <= RUN;
          end else if (wrap) begin
            state   <= IDLE;
            running <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase

      // A ratio only ever waits in pend while cfg_ready is low, so apply and accept never collide.
      if (apply) begin
        cur_div    <= pend_div;
        pend_valid <= 1'b0;
        cfg_ready  <= 1'b1;
      end else if (accept && legal) begin
        pend_div   <= cfg_div;
        pend_valid <= 1'b1;
        cfg_ready  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time programmable clock divider with a configuration handshake, enable sequencing and glitch-free ratio switching. It replaces fixed-ratio dividers such as the divide-by-5: software or a parent FSM loads a ratio, and the block applies it only at an output-period boundary. Any ratio from 2 to 2^CNT_W-1 gives a 50 % duty output; odd ratios use a negedge phase flop.

## Interface
- CNT_W, default 8: width of the divide ratio and the period counter.
- DEFAULT_DIV, default 5: ratio loaded at reset. Must be ≥ 2.
- clk  input  1  divider source clock. All logic uses its posedge, except the single odd-ratio phase flop, which uses its negedge.
- rst  input  1  asynchronous, active-high reset; clears every flop, including the negedge flop.
- en  input  1  run request, level-sensitive.
- cfg_valid  input  1  a new ratio is offered.
- cfg_div  input  CNT_W  the offered ratio; sampled when cfg_valid and cfg_ready are both high.
- cfg_ready  output  1  the block can accept a ratio.
- cfg_err  output  1  one-cycle pulse: an offered ratio below 2 was rejected.
- clk_out  output  1  divided clock.
- tick  output  1  one-cycle pulse on the posedge where a clk_out period starts.
- cur_div  output  CNT_W  ratio currently in effect.
- running  output  1  high while in RUN or STOP.

## Operation
- **States:**
  - IDLE: clk_out low, counter held at 0.
  - RUN: dividing.
  - STOP: en has dropped; the current period is finishing.
- **Transitions:**
  - IDLE → RUN on en = 1. The first period starts on the next posedge.
  - RUN → STOP on en = 0.
  - STOP → RUN if en returns high before the boundary. The output continues with no gap.
  - STOP → IDLE at the boundary if en is still low.
- **Counter:** cnt counts 0 .. cur_div-1 and wraps to 0. The wrap edge is the period boundary.
- **Phase flops:**
  - pos_q is high while cnt < floor(cur_div/2).
  - neg_q is pos_q captured on the negedge of clk.
  - Even ratio: clk_out = pos_q.
  - Odd ratio: clk_out = pos_q | neg_q, which gives cur_div/2 cycles high.
- **Handshake:**
  - A transfer occurs when cfg_valid & cfg_ready.
  - cfg_div ≥ 2: the value goes into the pending register and cfg_ready drops.
  - cfg_div < 2: cfg_err pulses on the next cycle, nothing is stored, and cfg_ready stays high.
- **Applying a pending ratio:**
  - IDLE: copied to cur_div on the next posedge.
  - RUN or STOP: copied on the first boundary strictly after the acceptance edge; that new period uses the new ratio.
  - cfg_ready returns high on the same edge the ratio is applied.
- **Boundary conditions:**
  - Offer accepted on the same edge as a wrap: applied at the following wrap, not this one.
  - en falls while a ratio is pending: the pending ratio is still applied at the boundary that enters IDLE.
  - tick is never asserted in IDLE.

## Timing
- **Reset values:**
  - Outputs: clk_out 0, tick 0, cfg_err 0, cfg_ready 1, running 0, cur_div = DEFAULT_DIV.
  - Internal: state IDLE, cnt 0, pending register empty.
- **Start latency:** clk_out rises on the second posedge after en is sampled high. tick is high for that same clk cycle.
- **Steady-state period:** exactly cur_div clk cycles, rising edge to rising edge.
- **High time:**
  - Even ratio: cur_div/2 cycles.
  - Odd ratio: cur_div/2 cycles (for example 2.5 for ratio 5). The falling edge is aligned to a negedge of clk.
- **Glitch-freedom:** no clk_out pulse shorter than floor(min(old, new)/2) cycles at any ratio switch or at stop.
- **Reset mid-period:** clk_out goes low asynchronously, and all state returns to the reset values.

## Structure
- **clk_div_pkg:**
  - state enum: IDLE, RUN, STOP.
  - MIN_DIV = 2.
  - function half(div) returning floor(div/2).
- **clk_div_core:** sub-module holding cnt, pos_q and neg_q, plus the clk_out combine.
  - Inputs: clear, run, div.
  - Outputs: wrap, clk_out.
- **clk_div_ctrl:** top level holding the FSM, the pending register, the handshake and tick/cfg_err generation.

## Test plan
- **Reset and default ratio:** apply reset, then en = 1 with no configuration → clk_out period 50 ns, high time 25 ns (ratio 5 at a 10 ns clk); tick every 5 cycles; cur_div = 5.
- **Even reprogramming:** offer cfg_div = 4 mid-period → cfg_ready low until the next wrap; after the wrap, period 40 ns with 20 ns high; no short pulse at the switch.
- **Illegal ratios:** offer cfg_div = 0 and then 1 → cfg_err pulses once for each; cur_div unchanged; cfg_ready stays high.
- **Graceful stop:** drop en at cnt = 1 with ratio 6 → the period completes (6 cycles total) and clk_out then stays low. Also re-raise en during STOP → periods continue back to back.
- **Same-edge collision:** accept cfg_div = 3 on the exact wrap edge → one more period at the old ratio, then a 30 ns period with 15 ns high.
- **Reset mid-operation:** assert rst while clk_out is high → clk_out falls immediately. After release, all outputs match the reset values and cur_div = DEFAULT_DIV.
